meas_gate_ctrl: RTL

//   Sequencer for the equal-precision (reciprocal) frequency meter. Generates the

---
 rtl/meas_gate_ctrl_pkg.sv | 19 +
 rtl/fx_edge_sync.sv | 25 ++
 rtl/meas_gate_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/meas_gate_ctrl_pkg.sv
// Shared definitions for the reciprocal frequency-meter gate sequencer:
// FSM state encoding, count width and default timing constants.
package meas_gate_ctrl_pkg;

   localparam int          CNT_W          = 32;
   localparam int          GATE_W_DEF     = 24;
   localparam int          TMO_W_DEF      = 24;
   localparam logic [23:0] TMO_CYC_DEF    = 24'hFF_FFFF;
   localparam int          SETTLE_CYC_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GATE   = 3'd1,
      ST_CLOSE  = 3'd2,
      ST_SETTLE = 3'd3,
      ST_HOLD   = 3'd4
   } state_t;

endpackage

// File: rtl/fx_edge_sync.sv
// Brings the asynchronous fx input into the clk domain and emits a one-cycle
// pulse per rising edge; a rising fx appears on fx_rise three edges later.
module fx_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic fx,
   output logic fx_rise
);

   // [0] and [1] form the metastability chain, [2] holds the previous sample
   logic [2:0] sync_q;

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         fx_rise <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], fx};
         fx_rise <= sync_q[1] & ~sync_q[2];
      end
   end

endmodule

// File: rtl/meas_gate_ctrl.sv
// Gate sequencer for the equal-precision frequency meter: opens fgate for a
// programmed number of clk cycles, waits for the fx close edge, then hands off counts.
module meas_gate_ctrl
   import meas_gate_ctrl_pkg::*;
#(
   parameter int               GATE_W     = GATE_W_DEF,
   parameter int               TMO_W      = TMO_W_DEF,
   parameter logic [TMO_W-1:0] TMO_CYC    = TMO_W'(TMO_CYC_DEF),
   parameter int               SETTLE_CYC = SETTLE_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              continuous,
   input  logic [GATE_W-1:0] gate_len,
   input  logic              fx,
   input  logic [CNT_W-1:0]  fx_cnt,
   input  logic [CNT_W-1:0]  fbase_cnt,
   output logic              fgate,
   output logic              busy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CNT_W-1:0]  res_fx_cnt,
   output logic [CNT_W-1:0]  res_fbase_cnt,
   output logic              timeout
);

   localparam int SET_W = $clog2(SETTLE_CYC + 1);

   state_t              state_q, state_d;
   logic [GATE_W-1:0]   len_q, len_d;
   logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
   logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
   logic                fgate_d, valid_d, timeout_d;
   logic [CNT_W-1:0]    rfx_d, rfb_d;
   logic                fx_rise;

   fx_edge_sync u_fx_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .fx      (fx),
      .fx_rise (fx_rise)
   );

   assign busy = (state_q != ST_IDLE);

   // NOTE: every next-state variable takes its hold value before the case, so
   // paths that do not assign it cannot infer a latch.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      gate_cnt_d = gate_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      set_cnt_d  = set_cnt_q;
      fgate_d    = fgate;
      valid_d    = res_valid;
      rfx_d      = res_fx_cnt;
      rfb_d      = res_fbase_cnt;
      timeout_d  = timeout;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d      = (gate_len == '0) ? GATE_W'(1) : gate_len;
               gate_cnt_d = len_d;
               timeout_d  = 1'b0;
               fgate_d    = 1'b1;
               state_d    = ST_GATE;
            end
         end
         ST_GATE: begin
            if (gate_cnt_q == GATE_W'(1)) begin
               fgate_d   = 1'b0;
               tmo_cnt_d = TMO_W'(1);
               state_d   = ST_CLOSE;
            end else begin
               gate_cnt_d = gate_cnt_q - GATE_W'(1);
            end
         end
         ST_CLOSE: begin
            // The meter closes its own gate on this fx edge and latches its counts
            if (fx_rise) begin
               set_cnt_d = SET_W'(SETTLE_CYC);
               state_d   = ST_SETTLE;
            end else if (tmo_cnt_q == TMO_CYC) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         ST_SETTLE: begin
            if (set_cnt_q == SET_W'(1)) begin
               rfx_d   = fx_cnt;
               rfb_d   = fbase_cnt;
               valid_d = 1'b1;
               state_d = ST_HOLD;
            end else begin
               set_cnt_d = set_cnt_q - SET_W'(1);
            end
         end
         ST_HOLD: begin
            if (res_ready) begin
               valid_d = 1'b0;
               if (continuous) begin
                  gate_cnt_d = len_q;
                  fgate_d    = 1'b1;
                  state_d    = ST_GATE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: the result registers are ordinary flops, not a memory, so they are
   // reset along with the control state and read as zero until the first capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         len_q         <= GATE_W'(1);
         gate_cnt_q    <= '0;
         tmo_cnt_q     <= '0;
         set_cnt_q     <= '0;
         fgate         <= 1'b0;
         res_valid     <= 1'b0;
         res_fx_cnt    <= '0;
         res_fbase_cnt <= '0;
         timeout       <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         gate_cnt_q    <= gate_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
         set_cnt_q     <= set_cnt_d;
         fgate         <= fgate_d;
         res_valid     <= valid_d;
         res_fx_cnt    <= rfx_d;
         res_fbase_cnt <= rfb_d;
         timeout       <= timeout_d;
      end
   end

endmodule
